// File: rtl/div_seq_param_pkg.sv
// Shared definitions for the iterative restoring divider: default widths,
// FSM state encoding and the result latency helper.
package div_seq_param_pkg;

    localparam int DEF_DIVIDEND_W = 29;
    localparam int DEF_DIVISOR_W  = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    // Enabled cycles from the acceptance edge (inclusive) until out_valid is seen.
    function automatic int div_lat(input int dividend_w);
        return dividend_w + 2;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract
// the divisor magnitude and keep or restore the partial remainder.
module div_restore_step #(
    parameter int DIVISOR_W = 21
) (
    input  logic [DIVISOR_W-1:0] rem,
    input  logic                 next_bit,
    input  logic [DIVISOR_W-1:0] divisor_mag,
    output logic [DIVISOR_W-1:0] rem_next,
    output logic                 q_bit
);

    logic [DIVISOR_W:0]   shifted;
    logic [DIVISOR_W-1:0] diff;

    always_comb begin
        shifted  = {rem, next_bit};
        // The kept difference is always below the divisor, so the low bits suffice.
        diff     = shifted[DIVISOR_W-1:0] - divisor_mag;
        q_bit    = (shifted >= {1'b0, divisor_mag});
        rem_next = q_bit ? diff : shifted[DIVISOR_W-1:0];
    end

endmodule

// File: rtl/div_seq_param.sv
// Parametrised radix-2 restoring divider, one quotient bit per enabled cycle,
// with valid/ready handshakes, signed mode and divide-by-zero reporting.
module div_seq_param
    import div_seq_param_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W,
    parameter bit SIGNED_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_signed,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    div_state_t            state, state_nxt;
    logic [DIVIDEND_W-1:0] q_reg;
    logic [DIVISOR_W-1:0]  rem_reg;
    logic [DIVISOR_W-1:0]  dvs_mag;
    logic [CNT_W-1:0]      cnt;
    logic                  neg_q, neg_r, zero_div;
    logic                  sgn, accept, divisor_zero;
    logic [DIVISOR_W-1:0]  step_rem;
    logic                  step_q;

    function automatic logic [DIVIDEND_W-1:0] neg_dvd(input logic [DIVIDEND_W-1:0] v,
                                                      input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [DIVISOR_W-1:0] neg_dvs(input logic [DIVISOR_W-1:0] v,
                                                     input logic n);
        return n ? -v : v;
    endfunction

    assign sgn          = SIGNED_EN & in_signed;
    assign divisor_zero = (divisor == '0);
    assign in_ready     = (state == IDLE) && !reset;
    assign accept       = in_valid && in_ready && clken;
    assign out_valid    = (state == DONE);
    assign busy         = (state != IDLE);

    div_restore_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .rem         (rem_reg),
        .next_bit    (q_reg[DIVIDEND_W-1]),
        .divisor_mag (dvs_mag),
        .rem_next    (step_rem),
        .q_bit       (step_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: next-state is defaulted to the current state first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (clken) begin
            case (state)
                IDLE: if (accept) state_nxt = divisor_zero ? FIX : CALC;
                CALC: if (cnt == '0) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg       <= '0;
            rem_reg     <= '0;
            dvs_mag     <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (clken) begin
            case (state)
                IDLE: if (accept) begin
                    zero_div <= divisor_zero;
                    neg_q    <= sgn & (dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1]);
                    neg_r    <= sgn & dividend[DIVIDEND_W-1];
                    // A zero divisor skips CALC; keep the raw dividend for the remainder.
                    q_reg    <= divisor_zero ? dividend
                                             : neg_dvd(dividend, sgn & dividend[DIVIDEND_W-1]);
                    dvs_mag  <= neg_dvs(divisor, sgn & divisor[DIVISOR_W-1]);
                    rem_reg  <= '0;
                    cnt      <= CNT_W'(DIVIDEND_W - 1);
                end
                CALC: begin
                    q_reg   <= {q_reg[DIVIDEND_W-2:0], step_q};
                    rem_reg <= step_rem;
                    cnt     <= cnt - 1'b1;
                end
                FIX: begin
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= q_reg[DIVISOR_W-1:0];
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= neg_dvd(q_reg, neg_q);
                        remainder   <= neg_dvs(rem_reg, neg_r);
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_param.sv
// Self-checking bench for div_seq_param: directed corner cases, clken waveform,
// mid-operation reset and randomised operands against a C-semantics model.
module tb_div_seq_param;
    import div_seq_param_pkg::*;

    localparam int N = DEF_DIVIDEND_W;
    localparam int M = DEF_DIVISOR_W;

    typedef struct {
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         clken = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_signed = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [M-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    int   vectors = 0;
    int   miscompares = 0;
    logic pass = 1'b0;
    logic fail = 1'b0;

    int   cyc = 0;
    int   ck_mode = 0;
    int   or_mode = 0;
    logic or_val = 1'b1;
    int   wave_cnt = 0;

    exp_t sb[$];
    exp_t pend;
    int   acc_count = 0;
    int   last_acc_cyc = 0;
    bit   tracking = 1'b0;
    int   lat = 0;
    int   lat_exp = 0;
    bit   ov_prev = 1'b0;
    bit   hs_prev = 1'b0;
    logic [N-1:0] q_prev;
    logic [M-1:0] r_prev;
    logic         dz_prev;

    div_seq_param dut (
        .clk         (clk),
        .reset       (reset),
        .clken       (clken),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #25 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Enable and consumer-ready generators: 50 ns period, 390 on / 416 off waveform.
    always @(posedge clk) begin
        #1;
        case (ck_mode)
            0:       clken = 1'b1;
            1:       clken = ($urandom_range(0, 99) < 80);
            default: clken = (wave_cnt < 390);
        endcase
        wave_cnt = (wave_cnt == 805) ? 0 : wave_cnt + 1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 99) < 75);
            default: out_ready = or_val;
        endcase
    end

    // Monitor: samples on the falling edge what the next rising edge will do.
    always @(negedge clk) begin
        exp_t e;
        bit   hs;
        if (reset) begin
            sb.delete();
            tracking = 1'b0;
            ov_prev  = 1'b0;
            hs_prev  = 1'b0;
        end else begin
            if (tracking && out_valid) begin
                check("latency", lat, lat_exp);
                tracking = 1'b0;
            end
            if (ov_prev && !hs_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_quotient", quotient, q_prev);
                check("hold_remainder", remainder, r_prev);
                check("hold_dz", div_by_zero, dz_prev);
            end
            hs = out_valid && out_ready && clken;
            if (hs) begin
                check("sb_nonempty", (sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_by_zero", div_by_zero, e.dz);
                end
            end
            if (tracking && clken) lat++;
            if (in_valid && in_ready && clken) begin
                sb.push_back(pend);
                lat_exp      = pend.lat;
                lat          = 1;
                tracking     = 1'b1;
                last_acc_cyc = cyc;
                acc_count++;
            end
            ov_prev = out_valid;
            hs_prev = hs;
            q_prev  = quotient;
            r_prev  = remainder;
            dz_prev = div_by_zero;
        end
    end

    function automatic exp_t mk_exp(input logic [N-1:0] q, input logic [M-1:0] r, input logic dz);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dz  = dz;
        e.lat = dz ? 2 : div_lat(N);
        return e;
    endfunction

    // Reference model with C '/' and '%' semantics (truncation toward zero).
    function automatic exp_t model(input logic [N-1:0] a, input logic [M-1:0] b, input logic s);
        logic signed [N-1:0] as_;
        logic signed [M-1:0] bs_;
        logic [N-1:0]        bz;
        int                  ai, bi, qi, ri;
        if (b == '0) return mk_exp('1, a[M-1:0], 1'b1);
        if (!s) begin
            bz = N'(b);
            return mk_exp(a / bz, M'(a % bz), 1'b0);
        end
        as_ = a;
        bs_ = b;
        ai  = as_;
        bi  = bs_;
        qi  = ai / bi;
        ri  = ai % bi;
        return mk_exp(N'(qi), M'(ri), 1'b0);
    endfunction

    task automatic do_op(input logic [N-1:0] a, input logic [M-1:0] b, input logic s,
                         input exp_t e);
        int n0;
        int k;
        n0 = acc_count;
        @(posedge clk);
        #1;
        pend      = e;
        dividend  = a;
        divisor   = b;
        in_signed = s;
        in_valid  = 1'b1;
        k = 0;
        while (acc_count == n0 && k < 5000) begin
            @(posedge clk);
            k++;
        end
        check("accept_timeout", (acc_count != n0), 1);
        #1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", (k < 5000), 1);
    endtask

    task automatic wait_out_valid();
        int k;
        k = 0;
        while (!out_valid && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("out_valid_timeout", out_valid, 1);
    endtask

    initial begin
        logic [N-1:0] a;
        logic [M-1:0] b;
        logic         s;
        int           t0;
        int           sel;

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready_rel", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);

        // Directed arithmetic
        do_op(29'd8, 21'd4, 1'b0, mk_exp(29'd2, 21'd0, 1'b0));
        drain();
        do_op(29'h1FFFFFFF, 21'h1FFFFF, 1'b0, mk_exp(29'h100, 21'hFF, 1'b0));
        do_op(29'h1FFFFFF9, 21'd2, 1'b1, mk_exp(29'h1FFFFFFD, 21'h1FFFFF, 1'b0));
        drain();
        do_op(29'd100, 21'd0, 1'b0, mk_exp(29'h1FFFFFFF, 21'd100, 1'b1));
        drain();
        do_op(29'h10000000, 21'h1FFFFF, 1'b1, mk_exp(29'h10000000, 21'd0, 1'b0));
        drain();

        // Back-to-back throughput with out_ready held high
        do_op(29'd1000, 21'd7, 1'b0, mk_exp(29'd142, 21'd6, 1'b0));
        t0 = last_acc_cyc;
        do_op(29'd77, 21'd10, 1'b0, mk_exp(29'd7, 21'd7, 1'b0));
        check("throughput", last_acc_cyc - t0, N + 3);
        drain();

        // Mid-operation reset around CALC step 10, then a fresh operation
        do_op(29'd8, 21'd4, 1'b0, mk_exp(29'd2, 21'd0, 1'b0));
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready_rel", in_ready, 1);
        do_op(29'd8, 21'd4, 1'b0, mk_exp(29'd2, 21'd0, 1'b0));
        drain();

        // clken waveform with out_ready stalls
        ck_mode = 2;
        for (int i = 0; i < 30; i++) begin
            a = N'($urandom);
            b = (i % 7 == 3) ? '0 : M'($urandom_range(1, 2000));
            s = i[0];
            do_op(a, b, s, model(a, b, s));
            if (i == 5) begin
                or_val  = 1'b0;
                or_mode = 2;
                wait_out_valid();
                repeat (10) @(posedge clk);
                @(negedge clk);
                check("stall_out_valid", out_valid, 1);
                or_mode = 0;
            end
        end
        drain();

        // Randomised operands, both modes, random clken and out_ready
        ck_mode = 1;
        or_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            a   = N'($urandom);
            s   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 19);
            if (sel == 0) begin
                b = '0;
            end else if (sel == 1) begin
                a = {1'b1, {(N-1){1'b0}}};
                b = '1;
                s = 1'b1;
            end else if (sel < 7) begin
                b = M'($urandom_range(1, 15));
            end else begin
                b = M'($urandom);
            end
            do_op(a, b, s, model(a, b, s));
        end
        drain();

        pass = (miscompares == 0);
        fail = !pass;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
